// File: rtl/jtframe_dwnld.sv
// Turns the io controller byte stream into SDRAM programming requests with a
// one-byte holding buffer, plus a separate PROM write strobe and busy/tail logic.
module jtframe_dwnld #(
  parameter logic [24:0] BA1_START  = 25'h100_0000,
  parameter logic [24:0] BA2_START  = 25'h100_0000,
  parameter logic [24:0] BA3_START  = 25'h100_0000,
  parameter logic [24:0] PROM_START = 25'h1ff_ffff,
  parameter bit          SWAB       = 1'b0,
  parameter int          TAIL       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  output logic        prog_rd,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int TW = (TAIL < 1) ? 1 : $clog2(TAIL + 1);
  localparam logic [TW-1:0] TAIL_V = TW'(TAIL);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t      state;
  logic        is_prom;
  logic [1:0]  dec_bank;
  logic [24:0] bank_start;
  logic [24:0] offset;
  logic [24:0] prom_off;
  logic [21:0] dec_addr;
  logic [1:0]  dec_mask;
  logic        sd_wr;
  logic        pr_wr;

  logic [21:0] sd_addr;
  logic [7:0]  sd_data;
  logic [1:0]  sd_mask;
  logic [1:0]  sd_bank;

  logic        buf_valid;
  logic [21:0] buf_addr;
  logic [7:0]  buf_data;
  logic [1:0]  buf_mask;
  logic [1:0]  buf_bank;

  logic [21:0] prom_addr;
  logic [7:0]  prom_data;
  logic [TW-1:0] tail_cnt;

  logic unused_bits;
  assign unused_bits = ^{offset[24:23], prom_off[24:22]};

  // Address decode: PROM region wins, otherwise the highest bank whose start is reached.
  always_comb begin
    is_prom    = (ioctl_addr >= PROM_START);
    dec_bank   = 2'd0;
    bank_start = 25'd0;
    if (ioctl_addr >= BA3_START) begin
      dec_bank   = 2'd3;
      bank_start = BA3_START;
    end else if (ioctl_addr >= BA2_START) begin
      dec_bank   = 2'd2;
      bank_start = BA2_START;
    end else if (ioctl_addr >= BA1_START) begin
      dec_bank   = 2'd1;
      bank_start = BA1_START;
    end
    offset   = ioctl_addr - bank_start;
    prom_off = ioctl_addr - PROM_START;
    dec_addr = offset[22:1];
    dec_mask = (offset[0] ^ SWAB) ? 2'b01 : 2'b10;
  end

  assign sd_wr = ioctl_wr & downloading & ~is_prom;
  assign pr_wr = ioctl_wr & downloading & is_prom;

  // PROM fields only show on the outputs during their one-cycle strobe.
  assign prog_addr  = prom_we ? prom_addr : sd_addr;
  assign prog_data  = prom_we ? prom_data : sd_data;
  assign prog_mask  = sd_mask;
  assign prog_bank  = sd_bank;
  assign prog_rd    = 1'b0;
  assign dwnld_busy = downloading | prog_we | buf_valid | (tail_cnt != '0);

  // GAP is the cycle after an ack: either the buffered byte is reissued or a
  // fresh byte is taken as if idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prom_we   <= 1'b0;
      overflow  <= 1'b0;
      sd_addr   <= '0;
      sd_data   <= '0;
      sd_mask   <= 2'b11;
      sd_bank   <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_mask  <= 2'b11;
      buf_bank  <= '0;
      prom_addr <= '0;
      prom_data <= '0;
      tail_cnt  <= '0;
    end else begin
      prom_we <= pr_wr;
      if (pr_wr) begin
        prom_addr <= prom_off[21:0];
        prom_data <= ioctl_data;
      end

      case (state)
        IDLE: begin
          if (sd_wr) begin
            sd_addr <= dec_addr;
            sd_data <= ioctl_data;
            sd_mask <= dec_mask;
            sd_bank <= dec_bank;
            prog_we <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            prog_we <= 1'b0;
            state   <= GAP;
          end
          if (sd_wr) begin
            if (!buf_valid) begin
              buf_addr  <= dec_addr;
              buf_data  <= ioctl_data;
              buf_mask  <= dec_mask;
              buf_bank  <= dec_bank;
              buf_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        GAP: begin
          if (buf_valid) begin
            sd_addr   <= buf_addr;
            sd_data   <= buf_data;
            sd_mask   <= buf_mask;
            sd_bank   <= buf_bank;
            prog_we   <= 1'b1;
            state     <= REQ;
            buf_valid <= sd_wr;
            if (sd_wr) begin
              buf_addr <= dec_addr;
              buf_data <= ioctl_data;
              buf_mask <= dec_mask;
              buf_bank <= dec_bank;
            end
          end else if (sd_wr) begin
            sd_addr <= dec_addr;
            sd_data <= ioctl_data;
            sd_mask <= dec_mask;
            sd_bank <= dec_bank;
            prog_we <= 1'b1;
            state   <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Busy is held for TAIL cycles once the path has fully drained.
      if (downloading || prog_we || buf_valid) begin
        tail_cnt <= TAIL_V;
      end else if (tail_cnt != '0) begin
        tail_cnt <= tail_cnt - TW'(1);
      end
    end
  end

endmodule
